// File: rtl/move_input_pacer.sv
// Paddle button conditioner: sync -> debounce -> direction FSM -> one-cycle paced move strobes.
// Optional speed-up after a run of strobes is enabled by defining MOVE_ACCEL_EN.
module move_input_pacer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STEP_DIV        = 200000,
  parameter int ACCEL_AFTER     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       left,
  output logic       right,
  output logic       held_left,
  output logic       held_right,
  output logic [1:0] dir_state
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PACE_W = $clog2(STEP_DIV);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_L  = 2'd1,
    MOVE_R  = 2'd2,
    BLOCKED = 2'd3
  } dir_t;

  if (DEBOUNCE_CYCLES < 2 || STEP_DIV < 2 || (STEP_DIV % 2) != 0 || ACCEL_AFTER < 1) begin : g_bad_params
    $error("move_input_pacer: illegal parameter combination");
  end

  logic [1:0]            sync_l_q, sync_r_q;
  logic [1:0]            sync_s;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]            held_q, held_d;
  dir_t                  state_q, state_d;
  logic [PACE_W-1:0]     pace_q, pace_d, pace_lim;
  logic                  left_q, left_d, right_q, right_d;
  logic                  trans, moving, strobe;

  assign sync_s = {sync_r_q[1], sync_l_q[1]};

  // Debounce: held level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    held_d   = held_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_s[i] != held_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) held_d[i] = ~held_q[i];
        else                                           db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Direction FSM and pacing; strobes key off the next state so leaving a move never strobes
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (held_q[0] && !held_q[1])      state_d = MOVE_L;
        else if (held_q[1] && !held_q[0]) state_d = MOVE_R;
        else if (held_q[0] && held_q[1])  state_d = BLOCKED;
      end
      MOVE_L: begin
        if (!held_q[0] && !held_q[1]) state_d = IDLE;
        else if (held_q[1])           state_d = BLOCKED;
      end
      MOVE_R: begin
        if (!held_q[0] && !held_q[1]) state_d = IDLE;
        else if (held_q[0])           state_d = BLOCKED;
      end
      BLOCKED: begin
        if (held_q[0] && !held_q[1])        state_d = MOVE_L;
        else if (held_q[1] && !held_q[0])   state_d = MOVE_R;
        else if (!held_q[0] && !held_q[1])  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    trans  = (state_d != state_q);
    moving = (state_d == MOVE_L) || (state_d == MOVE_R);
    pace_d = '0;
    strobe = 1'b0;
    if (trans) begin
      strobe = moving;
    end else if (moving) begin
      if (pace_q == pace_lim) strobe = 1'b1;
      else                    pace_d = pace_q + 1'b1;
    end
    left_d  = strobe && (state_d == MOVE_L);
    right_d = strobe && (state_d == MOVE_R);
  end

`ifdef MOVE_ACCEL_EN
  localparam int RUN_W = $clog2(ACCEL_AFTER + 1);
  logic [RUN_W-1:0] run_q, run_d;

  // The entry strobe counts as the first strobe of a run
  always_comb begin
    run_d = run_q;
    if (trans)                                          run_d = strobe ? RUN_W'(1) : '0;
    else if (strobe && run_q != RUN_W'(ACCEL_AFTER))    run_d = run_q + 1'b1;
  end

  assign pace_lim = (run_q == RUN_W'(ACCEL_AFTER)) ? PACE_W'(STEP_DIV / 2 - 1)
                                                   : PACE_W'(STEP_DIV - 1);

  always_ff @(posedge clk) begin
    if (reset) run_q <= '0;
    else       run_q <= run_d;
  end
`else
  assign pace_lim = PACE_W'(STEP_DIV - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_l_q <= '0;
      sync_r_q <= '0;
      db_cnt_q <= '0;
      held_q   <= '0;
      state_q  <= IDLE;
      pace_q   <= '0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
    end else begin
      sync_l_q <= {sync_l_q[0], btn_left};
      sync_r_q <= {sync_r_q[0], btn_right};
      db_cnt_q <= db_cnt_d;
      held_q   <= held_d;
      state_q  <= state_d;
      pace_q   <= pace_d;
      left_q   <= left_d;
      right_q  <= right_d;
    end
  end

  assign left       = left_q;
  assign right      = right_q;
  assign held_left  = held_q[0];
  assign held_right = held_q[1];
  assign dir_state  = state_q;

endmodule

// File: tb/tb_move_input_pacer.sv
// Directed bench for move_input_pacer with DEBOUNCE_CYCLES=4, STEP_DIV=8, ACCEL_AFTER=3.
module tb_move_input_pacer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_left, btn_right;
  logic       left, right, held_left, held_right;
  logic [1:0] dir_state;

  int n_tests = 0;
  int n_fail  = 0;

  move_input_pacer #(
    .DEBOUNCE_CYCLES(4),
    .STEP_DIV       (8),
    .ACCEL_AFTER    (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .left      (left),
    .right     (right),
    .held_left (held_left),
    .held_right(held_right),
    .dir_state (dir_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit left_due(int k);
`ifdef MOVE_ACCEL_EN
    return (k == 6) || (k == 14) || (k == 22) || (k >= 26 && ((k - 26) % 4) == 0);
`else
    return (k >= 6) && (((k - 6) % 8) == 0);
`endif
  endfunction

  initial begin
    reset     = 1'b1;
    btn_left  = 1'b0;
    btn_right = 1'b0;

    // 1: reset held, everything stays zero
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_outs_e%0d", k), {held_left, held_right, left, right, dir_state}, 6'd0);
    end

    // 2: left held 40 cycles from edge 0
    reset    = 1'b0;
    btn_left = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk($sformatf("t2_held_l_e%0d", k), held_left, (k >= 5));
      chk($sformatf("t2_strobe_e%0d", k), {left, right}, {left_due(k), 1'b0});
      if (k == 6) chk("t2_dir_e6", dir_state, 2'd1);
    end

    // 3: right glitch of 3 cycles never debounces
    btn_right = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) btn_right = 1'b0;
      tick();
      chk($sformatf("t3_held_r_e%0d", k), held_right, 1'b0);
      chk($sformatf("t3_right_e%0d", k), right, 1'b0);
      chk($sformatf("t3_dir_e%0d", k), dir_state, 2'd1);
    end

    // 4a: right pressed while moving left -> BLOCKED, strobes stop
    btn_right = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("t4a_held_r_e%0d", k), held_right, (k >= 5));
      chk($sformatf("t4a_dir_e%0d", k), dir_state, (k >= 6) ? 2'd3 : 2'd1);
      chk($sformatf("t4a_right_e%0d", k), right, 1'b0);
      if (k >= 6) chk($sformatf("t4a_left_e%0d", k), left, 1'b0);
    end

    // 4b: left released -> MOVE_R with entry strobe at edge 6, next at 14
    btn_left = 1'b0;
    for (int k = 0; k < 22; k++) begin
      tick();
      chk($sformatf("t4b_held_l_e%0d", k), held_left, (k < 5));
      chk($sformatf("t4b_dir_e%0d", k), dir_state, (k >= 6) ? 2'd2 : 2'd3);
      chk($sformatf("t4b_strobe_e%0d", k), {left, right}, {1'b0, (k == 6) || (k == 14)});
    end

    // 5: reset sampled on the edge the third right strobe (edge 22) was due
    reset = 1'b1;
    tick();
    chk("t5_outs_at_reset", {held_left, held_right, left, right, dir_state}, 6'd0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("t5_held_r_e%0d", k), held_right, (k >= 5));
      chk($sformatf("t5_strobe_e%0d", k), {left, right}, {1'b0, (k == 6)});
      chk($sformatf("t5_dir_e%0d", k), dir_state, (k >= 6) ? 2'd2 : 2'd0);
    end

    // 6: release right, then chatter on left every 2 cycles
    btn_right = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("t6_idle_dir", dir_state, 2'd0);
    chk("t6_idle_held_r", held_right, 1'b0);
    for (int k = 0; k < 36; k++) begin
      btn_left = (k < 30) ? (((k / 2) % 2) == 0) : 1'b0;
      tick();
      chk($sformatf("t6_held_l_e%0d", k), held_left, 1'b0);
      chk($sformatf("t6_left_e%0d", k), left, 1'b0);
      chk($sformatf("t6_dir_e%0d", k), dir_state, 2'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
